// File: rtl/boot_rom_pkg.sv
// Shared definitions for the boot ROM TileLink-UL responder and its checker benches.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package boot_rom_pkg;

  // TileLink A/D opcodes used by the ROM
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Boot stub image, word 0 sits at the ROM base address
  localparam logic [63:0] BOOT_IMAGE [8] = '{
    64'h0202_8593_0000_0297,
    64'h0182_b283_f140_2573,
    64'h0000_0013_0002_8067,
    64'hffdf_f06f_1050_0073,
    64'h0000_0000_0000_1000,
    64'hcafe_f00d_dead_beef,
    64'h0123_4567_89ab_cdef,
    64'hfedc_ba98_7654_3210
  };

endpackage

// File: rtl/boot_rom_if.sv
// TileLink-UL A/D channel bundle between a fetch/load master and the boot ROM.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both channels; master drives A and d_ready, slave drives D and a_ready.
interface boot_rom_if #(
  parameter int SRC_W = 4
);

  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [63:0]       a_address;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_denied;
  logic [63:0]       d_data;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
  );

endinterface

// File: rtl/boot_rom.sv
// Read-only TileLink-UL responder serving the 8x64-bit boot image; illegal requests get denied acks.
// Latency: A handshake in cycle N gives first D beat in N+1; bursts stream one beat per cycle.
// Backpressure: d_ready low holds the current beat; a_ready only while idle or on the accepted last beat.
// Ports: clk, rst_n (async active-low), bus (boot_rom_if slave: A request in, D response out).
module boot_rom
  import boot_rom_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_1000,
  parameter int unsigned DEPTH     = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  boot_rom_if.slave bus
);

  state_e      state;
  logic [3:0]  beat_cnt;
  logic [3:0]  last_cnt;
  logic [2:0]  word_idx;

  logic [63:0] addr_off;
  logic [63:0] word_off;
  logic [63:0] align_mask;
  logic [3:0]  req_beats;
  logic        req_get;
  logic        req_denied;
  logic        last_beat;
  logic        a_fire;
  logic        d_fire;

  // Request decode on the A channel
  always_comb begin
    req_get    = (bus.a_opcode == GET);
    addr_off   = bus.a_address - BASE_ADDR;
    word_off   = addr_off >> 3;
    align_mask = (64'd1 << bus.a_size) - 64'd1;

    // Writes and unknown opcodes are answered with a single ack beat
    if (!req_get || bus.a_size <= 3'd3 || bus.a_size > 3'd6)
      req_beats = 4'd1;
    else
      req_beats = 4'd1 << (bus.a_size - 3'd3);

    // Address below base wraps addr_off high, so the range test also catches it;
    // the explicit compare keeps the intent readable.
    req_denied = !req_get
              || (bus.a_address < BASE_ADDR)
              || (bus.a_size > 3'd6)
              || ((bus.a_address & align_mask) != 64'd0)
              || ((word_off + 64'(req_beats)) > 64'(DEPTH));
  end

  assign last_beat   = (beat_cnt == last_cnt);
  assign bus.d_valid = (state == RESP);
  // Accept a new request on the cycle the last beat drains, giving gap-free bursts
  assign bus.a_ready = rst_n & ((state == IDLE) | (last_beat & bus.d_ready));
  assign a_fire      = bus.a_valid & bus.a_ready;
  assign d_fire      = bus.d_valid & bus.d_ready;

  // Denied responses and acks for writes carry zero data
  assign bus.d_data = (bus.d_valid && !bus.d_denied) ? BOOT_IMAGE[word_idx + beat_cnt[2:0]] : 64'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      beat_cnt     <= 4'd0;
      last_cnt     <= 4'd0;
      word_idx     <= 3'd0;
      bus.d_opcode <= 3'd0;
      bus.d_size   <= 3'd0;
      bus.d_source <= '0;
      bus.d_denied <= 1'b0;
    end else if (a_fire) begin
      state        <= RESP;
      beat_cnt     <= 4'd0;
      last_cnt     <= req_beats - 4'd1;
      word_idx     <= word_off[2:0];
      bus.d_opcode <= req_get ? ACCESS_ACK_DATA : ACCESS_ACK;
      bus.d_size   <= bus.a_size;
      bus.d_source <= bus.a_source;
      bus.d_denied <= req_denied;
    end else if (d_fire) begin
      if (last_beat)
        state <= IDLE;
      else
        beat_cnt <= beat_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_boot_rom.sv
// Directed bench for boot_rom: scoreboard of expected D beats fed by the A-side driver.
// Latency: checks first beat at N+1 and zero-bubble burst chaining.
// Backpressure: exercises d_ready stalls and reset in the middle of a burst.
module tb_boot_rom;
  import boot_rom_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_1000;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic        den;
    logic [63:0] data;
  } beat_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  int    cyc   = 0;
  int    total = 0;
  int    bad   = 0;
  int    beats_seen = 0;
  beat_t exp_q[$];

  logic  stalled = 1'b0;
  beat_t held;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  boot_rom_if #(.SRC_W(4)) bus ();

  boot_rom #(.BASE_ADDR(BASE), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t dut_beat();
    beat_t b;
    b.op   = bus.d_opcode;
    b.size = bus.d_size;
    b.src  = bus.d_source;
    b.den  = bus.d_denied;
    b.data = bus.d_data;
    return b;
  endfunction

  // Reference model: expected response beats for one A request
  function automatic void push_model(input logic [2:0] op, input logic [2:0] sz,
                                     input logic [63:0] addr, input logic [3:0] src);
    logic  get;
    logic  den;
    int    beats;
    int    idx;
    beat_t b;
    get   = (op == 3'd4);
    beats = 1;
    if (get && sz > 3'd3 && sz <= 3'd6) beats = 1 << (sz - 3'd3);
    den = !get || (addr < BASE) || (sz > 3'd6) || ((addr % (64'd1 << sz)) != 64'd0)
          || (((addr - BASE) / 64'd8 + 64'(beats)) > 64'd8);
    idx = den ? 0 : int'((addr - BASE) / 64'd8);
    for (int k = 0; k < beats; k++) begin
      b.op   = get ? 3'd1 : 3'd0;
      b.size = sz;
      b.src  = src;
      b.den  = den;
      b.data = (get && !den) ? BOOT_IMAGE[idx + k] : 64'd0;
      exp_q.push_back(b);
    end
  endfunction

  task automatic send_a(input logic [2:0] op, input logic [2:0] sz, input logic [63:0] addr,
                        input logic [3:0] src, output int hs_cyc);
    int n;
    push_model(op, sz, addr, src);
    @(posedge clk); #1;
    bus.a_opcode  = op;
    bus.a_size    = sz;
    bus.a_address = addr;
    bus.a_source  = src;
    bus.a_valid   = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.a_ready) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $error("FAIL a_handshake_timeout: observed=no a_ready expected=a_ready within 200 cycles");
        bus.a_valid = 1'b0;
        hs_cyc = cyc;
        return;
      end
    end
    @(posedge clk); #1;
    hs_cyc      = cyc;
    bus.a_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 128'(exp_q.size()), 128'(0));
  endtask

  // Monitor: pops the scoreboard on every accepted beat, checks stall stability
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    if (!rst_n || !bus.d_valid) begin
      stalled = 1'b0;
    end else begin
      cur = dut_beat();
      if (stalled) check("stall_hold", 128'(cur), 128'(held));
      if (bus.d_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $error("FAIL unexpected_beat: observed=%0h expected=no beat", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", 128'(cur), 128'(e));
          beats_seen++;
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  sz;
    logic [63:0] addr;
    logic [3:0]  src;
  } req_t;

  initial begin
    int   hs1, hs2, b0;
    req_t tbl[11];

    bus.a_valid   = 1'b0;
    bus.a_opcode  = 3'd0;
    bus.a_size    = 3'd0;
    bus.a_source  = 4'd0;
    bus.a_address = 64'd0;
    bus.d_ready   = 1'b0;

    // Reset state
    #12;
    check("rst_a_ready",  128'(bus.a_ready),  128'(0));
    check("rst_d_valid",  128'(bus.d_valid),  128'(0));
    check("rst_d_data",   128'(bus.d_data),   128'(0));
    check("rst_d_opcode", 128'(bus.d_opcode), 128'(0));
    check("rst_d_size",   128'(bus.d_size),   128'(0));
    check("rst_d_source", 128'(bus.d_source), 128'(0));
    check("rst_d_denied", 128'(bus.d_denied), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_a_ready", 128'(bus.a_ready), 128'(1));

    // Single Get, response held by d_ready low
    send_a(GET, 3'd3, BASE + 64'h8, 4'd2, hs1);
    check("single_d_valid",  128'(bus.d_valid),  128'(1));
    check("single_d_opcode", 128'(bus.d_opcode), 128'(ACCESS_ACK_DATA));
    check("single_d_data",   128'(bus.d_data),   128'(BOOT_IMAGE[1]));
    check("single_d_source", 128'(bus.d_source), 128'(2));
    check("single_d_denied", 128'(bus.d_denied), 128'(0));
    check("single_a_ready",  128'(bus.a_ready),  128'(0));
    bus.d_ready = 1'b1;
    wait_drain("single_drain");

    // Back-to-back 8-beat bursts with d_ready high
    send_a(GET, 3'd6, BASE, 4'd1, hs1);
    check("burst_latency", 128'(bus.d_valid), 128'(1));
    send_a(GET, 3'd6, BASE, 4'd3, hs2);
    check("burst_gap", 128'(hs2 - hs1), 128'(8));
    check("no_bubble", 128'(bus.d_valid), 128'(1));
    check("no_bubble_src", 128'(bus.d_source), 128'(3));
    wait_drain("burst_drain");
    check("burst_a_ready", 128'(bus.a_ready), 128'(1));

    // Burst with d_ready toggling every cycle
    bus.d_ready = 1'b0;
    b0 = beats_seen;
    send_a(GET, 3'd6, BASE, 4'd5, hs1);
    for (int i = 0; i < 16; i++) begin
      bus.d_ready = (i % 2 == 1);
      @(posedge clk); #1;
    end
    check("toggle_beats", 128'(beats_seen - b0), 128'(8));
    check("toggle_empty", 128'(exp_q.size()), 128'(0));
    check("toggle_idle",  128'(bus.d_valid), 128'(0));
    bus.d_ready = 1'b1;

    // Denied and edge-case requests
    tbl = '{
      '{PUT_FULL,    3'd3, BASE,            4'd1},
      '{GET,         3'd3, BASE + 64'h40,   4'd2},
      '{GET,         3'd4, BASE + 64'h8,    4'd3},
      '{GET,         3'd7, BASE,            4'd4},
      '{GET,         3'd3, BASE - 64'h8,    4'd5},
      '{GET,         3'd2, BASE + 64'hC,    4'd6},
      '{GET,         3'd5, BASE + 64'h20,   4'd7},
      '{GET,         3'd5, BASE + 64'h28,   4'd8},
      '{PUT_PARTIAL, 3'd2, BASE + 64'h4,    4'd9},
      '{3'd2,        3'd3, BASE,            4'd10},
      '{GET,         3'd0, BASE + 64'h3F,   4'd11}
    };
    for (int i = 0; i < 11; i++) begin
      send_a(tbl[i].op, tbl[i].sz, tbl[i].addr, tbl[i].src, hs1);
      wait_drain("table_drain");
    end

    // Reset in the middle of a burst
    send_a(GET, 3'd6, BASE, 4'd12, hs1);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_d_valid", 128'(bus.d_valid), 128'(1));
    check("pre_rst_d_data",  128'(bus.d_data),  128'(BOOT_IMAGE[3]));
    rst_n = 1'b0;
    #1;
    check("mid_rst_d_valid", 128'(bus.d_valid), 128'(0));
    check("mid_rst_a_ready", 128'(bus.a_ready), 128'(0));
    check("mid_rst_d_data",  128'(bus.d_data),  128'(0));
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_a_ready", 128'(bus.a_ready), 128'(1));
      check("post_rst_d_valid", 128'(bus.d_valid), 128'(0));
    end
    b0 = beats_seen;
    send_a(GET, 3'd3, BASE, 4'd13, hs1);
    check("fresh_d_data", 128'(bus.d_data), 128'(BOOT_IMAGE[0]));
    wait_drain("fresh_drain");
    check("fresh_beats", 128'(beats_seen - b0), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
